evo_xb_info_table: RTL and testbench

//  Parametrised XB information block: read-only table of 32-bit info words on the Avalon MM CSR bus.
//  Two CSRs: INDEX (pointer/control) and DATA (window). Optional auto-increment streams the whole table.

---
 rtl/evo_xb_info_pkg.sv | 21 ++
 rtl/evo_xb_info_table_if.sv | 21 ++
 rtl/evo_rd_pipe.sv | 33 +++
 rtl/evo_xb_info_table.sv | 76 +++++++
 tb/tb_evo_xb_info_table.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/evo_xb_info_pkg.sv
// Shared CSR bus widths, plus the INDEX field layout and offsets of the XB info table.
package xb_csr_pkg;
  localparam int CSR_AWIDTH = 8;
  localparam int CSR_DWIDTH = 32;
endpackage

package evo_xb_info_pkg;
  localparam int INDEX_OFS   = 0;
  localparam int DATA_OFS    = 1;
  localparam int IDX_LSB     = 0;
  localparam int IDX_MSB     = 15;
  localparam int AUTOINC_BIT = 30;
  localparam int ERR_BIT     = 31;

  typedef struct packed {
    logic        err;
    logic        autoinc;
    logic [13:0] rsvd;
    logic [15:0] idx;
  } xb_info_index_t;
endpackage

// File: rtl/evo_xb_info_table_if.sv
// Avalon-MM CSR slave bundle of the XB info table.
interface evo_xb_info_table_if;
  import xb_csr_pkg::*;

  logic [CSR_AWIDTH-1:0] avs_csr_address;
  logic                  avs_csr_read;
  logic                  avs_csr_readdatavalid;
  logic                  avs_csr_waitrequest;
  logic                  avs_csr_write;
  logic [CSR_DWIDTH-1:0] avs_csr_writedata;
  logic [CSR_DWIDTH-1:0] avs_csr_readdata;

  modport master (
    output avs_csr_address, avs_csr_read, avs_csr_write, avs_csr_writedata,
    input  avs_csr_readdatavalid, avs_csr_waitrequest, avs_csr_readdata
  );
  modport slave (
    input  avs_csr_address, avs_csr_read, avs_csr_write, avs_csr_writedata,
    output avs_csr_readdatavalid, avs_csr_waitrequest, avs_csr_readdata
  );
endinterface

// File: rtl/evo_rd_pipe.sv
// Fixed-depth valid+data delay line; async clear drops anything in flight.
module evo_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         vld_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);
  logic [DEPTH-1:0]        vld_pipe;
  logic [DEPTH-1:0][W-1:0] dat_pipe;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      for (int k = DEPTH-1; k > 0; k--) begin
        vld_pipe[k] <= vld_pipe[k-1];
        dat_pipe[k] <= dat_pipe[k-1];
      end
      vld_pipe[0] <= vld_i;
      // data is zeroed at entry so readdata is 0 whenever valid is low
      dat_pipe[0] <= vld_i ? dat_i : '0;
    end
  end

  assign vld_o = vld_pipe[DEPTH-1];
  assign dat_o = dat_pipe[DEPTH-1];
endmodule

// File: rtl/evo_xb_info_table.sv
// Read-only table of 32-bit info words behind an INDEX/DATA CSR pair; entry 0 reports the entry count.
module evo_xb_info_table
  import xb_csr_pkg::*;
  import evo_xb_info_pkg::*;
#(
  parameter logic [31:0]                BASE_ADDR    = 32'h0,
  parameter int                         NUM_ENTRIES  = 3,
  parameter logic [NUM_ENTRIES*32-1:0]  INFO_TABLE   = {"PMUX", " EVO", " ALO"},
  parameter int                         READ_LATENCY = 1,
  parameter logic                       AUTOINC_RST  = 1'b0
) (
  input  logic               clk,
  input  logic               rstn,
  evo_xb_info_table_if.slave csr
);
  localparam logic [CSR_AWIDTH-1:0] IDX_ADDR = CSR_AWIDTH'(BASE_ADDR + INDEX_OFS);
  localparam logic [CSR_AWIDTH-1:0] DAT_ADDR = CSR_AWIDTH'(BASE_ADDR + DATA_OFS);

  xb_info_index_t        index_q, index_d;
  logic                  rd_ok, rd_idx, rd_dat, wr_idx;
  logic                  dat_err, idx_last;
  logic [CSR_DWIDTH-1:0] entry, rd_data;
  logic                  unused_wd;

  // a simultaneous write wins; the read is dropped
  assign rd_ok  = csr.avs_csr_read && !csr.avs_csr_write;
  assign rd_idx = rd_ok && (csr.avs_csr_address == IDX_ADDR);
  assign rd_dat = rd_ok && (csr.avs_csr_address == DAT_ADDR);
  assign wr_idx = csr.avs_csr_write && (csr.avs_csr_address == IDX_ADDR);

  assign idx_last = {16'd0, index_q.idx} >= 32'(NUM_ENTRIES);

  always_comb begin
    entry   = '0;
    dat_err = 1'b0;
    if (index_q.idx == 16'd0)
      entry = CSR_DWIDTH'(NUM_ENTRIES);
    else if ({16'd0, index_q.idx} > 32'(NUM_ENTRIES))
      dat_err = 1'b1;
    for (int e = 1; e <= NUM_ENTRIES; e++)
      if (index_q.idx == 16'(e)) entry = INFO_TABLE[32*e-1 -: 32];
  end

  always_comb begin
    index_d = index_q;
    if (wr_idx) begin
      index_d.idx     = csr.avs_csr_writedata[IDX_MSB:IDX_LSB];
      index_d.autoinc = csr.avs_csr_writedata[AUTOINC_BIT];
      if (csr.avs_csr_writedata[ERR_BIT]) index_d.err = 1'b0;
    end
    if (rd_dat && index_q.autoinc)
      index_d.idx = idx_last ? 16'd0 : index_q.idx + 16'd1;
    // set is applied after clear so a bad read beats a same-cycle W1C
    if (rd_dat && dat_err) index_d.err = 1'b1;
    index_d.rsvd = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) index_q <= '{err: 1'b0, autoinc: AUTOINC_RST, rsvd: 14'd0, idx: 16'd0};
    else       index_q <= index_d;
  end

  assign rd_data = rd_idx ? CSR_DWIDTH'(index_q) : entry;

  evo_rd_pipe #(.DEPTH(READ_LATENCY), .W(CSR_DWIDTH)) u_rd_pipe (
    .clk   (clk),
    .rstn  (rstn),
    .vld_i (rd_idx | rd_dat),
    .dat_i (rd_data),
    .vld_o (csr.avs_csr_readdatavalid),
    .dat_o (csr.avs_csr_readdata)
  );

  assign csr.avs_csr_waitrequest = 1'b0;
  assign unused_wd = ^csr.avs_csr_writedata[29:16];
endmodule

// File: tb/tb_evo_xb_info_table.sv
// Bench for the XB info table: latency-1 and latency-3 instances driven in lockstep against a table model.
module tb_evo_xb_info_table;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  evo_xb_info_table_if bus1();
  evo_xb_info_table_if bus3();

  evo_xb_info_table u_dut1 (.clk(clk), .rstn(rstn), .csr(bus1.slave));
  evo_xb_info_table #(.READ_LATENCY(3)) u_dut3 (.clk(clk), .rstn(rstn), .csr(bus3.slave));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[$];
  int vectors = 0;
  int miscompares = 0;

  // reference model: the table contents and INDEX fields as plain variables
  logic [31:0] ent [4];
  logic [15:0] m_idx;
  bit          m_ai, m_err;
  bit          h_v [3];
  logic [31:0] h_d [3];

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got vld=%b data=%h, want vld=%b data=%h",
               name, $time, got[32], got[31:0], exp[32], exp[31:0]);
    end
  endtask

  task automatic model_reset();
    m_idx = 16'd0; m_ai = 1'b0; m_err = 1'b0;
    for (int k = 0; k < 3; k++) begin h_v[k] = 1'b0; h_d[k] = 32'h0; end
  endtask

  task automatic model_op(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wd, output bit v, output logic [31:0] d);
    v = 1'b0; d = 32'h0;
    if (wr) begin
      if (addr == 8'd0) begin
        m_idx = wd[15:0];
        m_ai  = wd[30];
        if (wd[31]) m_err = 1'b0;
      end
    end else if (rd && addr == 8'd0) begin
      v = 1'b1;
      d = {m_err, m_ai, 14'b0, m_idx};
    end else if (rd && addr == 8'd1) begin
      v = 1'b1;
      if (m_idx <= 16'd3) d = ent[m_idx[1:0]];
      else m_err = 1'b1;
      if (m_ai) m_idx = (m_idx >= 16'd3) ? 16'd0 : m_idx + 16'd1;
    end
  endtask

  // one bus cycle: drive at negedge, clock, then compare both instances at the next negedge
  task automatic tick(input logic rd, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wd, output bit mv, output logic [31:0] md);
    bus1.avs_csr_read = rd; bus1.avs_csr_write = wr;
    bus1.avs_csr_address = addr; bus1.avs_csr_writedata = wd;
    bus3.avs_csr_read = rd; bus3.avs_csr_write = wr;
    bus3.avs_csr_address = addr; bus3.avs_csr_writedata = wd;
    model_op(rd, wr, addr, wd, mv, md);
    if (!rstn) begin mv = 1'b0; md = 32'h0; end
    h_v[2] = h_v[1]; h_d[2] = h_d[1];
    h_v[1] = h_v[0]; h_d[1] = h_d[0];
    h_v[0] = mv;     h_d[0] = md;
    @(posedge clk);
    @(negedge clk);
    check("lat1", {bus1.avs_csr_readdatavalid, bus1.avs_csr_readdata}, {mv, md});
    check("lat3", {bus3.avs_csr_readdatavalid, bus3.avs_csr_readdata}, {h_v[2], h_d[2]});
  endtask

  task automatic idle(input int n);
    bit v; logic [31:0] d;
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 8'd0, 32'h0, v, d);
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    model_reset();
    idle(n);
    rstn = 1'b1;
  endtask

  initial begin
    bit          mv;
    logic [31:0] md;

    ent[0] = 32'd3;
    ent[1] = 32'h2041_4C4F;  // " ALO"
    ent[2] = 32'h2045_564F;  // " EVO"
    ent[3] = 32'h504D_5558;  // "PMUX"
    model_reset();

    bus1.avs_csr_read = 1'b0; bus1.avs_csr_write = 1'b0;
    bus1.avs_csr_address = '0; bus1.avs_csr_writedata = '0;
    bus3.avs_csr_read = 1'b0; bus3.avs_csr_write = 1'b0;
    bus3.avs_csr_address = '0; bus3.avs_csr_writedata = '0;
    repeat (2) @(negedge clk);
    check("rst1", {bus1.avs_csr_readdatavalid, bus1.avs_csr_readdata}, 33'h0);
    check("rst3", {bus3.avs_csr_readdatavalid, bus3.avs_csr_readdata}, 33'h0);
    check("waitreq", {31'h0, bus1.avs_csr_waitrequest, bus3.avs_csr_waitrequest}, 33'h0);
    rstn = 1'b1;

    //               rd    wr    addr   wdata          ev    edata
    tbl.push_back('{1'b1, 1'b0, 8'd0, 32'h0000_0000, 1'b1, 32'h0000_0000});
    tbl.push_back('{1'b0, 1'b1, 8'd0, 32'h0000_0000, 1'b0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 8'd1, 32'h0000_0000, 1'b1, 32'h0000_0003});
    tbl.push_back('{1'b0, 1'b1, 8'd0, 32'h0000_0002, 1'b0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 8'd1, 32'h0000_0000, 1'b1, 32'h2045_564F});
    tbl.push_back('{1'b0, 1'b1, 8'd0, 32'h4000_0002, 1'b0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 8'd1, 32'h0000_0000, 1'b1, 32'h2045_564F});
    tbl.push_back('{1'b1, 1'b0, 8'd1, 32'h0000_0000, 1'b1, 32'h504D_5558});
    tbl.push_back('{1'b1, 1'b0, 8'd1, 32'h0000_0000, 1'b1, 32'h0000_0003});
    tbl.push_back('{1'b1, 1'b0, 8'd1, 32'h0000_0000, 1'b1, 32'h2041_4C4F});
    tbl.push_back('{1'b1, 1'b0, 8'd0, 32'h0000_0000, 1'b1, 32'h4000_0002});
    tbl.push_back('{1'b0, 1'b1, 8'd0, 32'h0000_0007, 1'b0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 8'd1, 32'h0000_0000, 1'b1, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 8'd0, 32'h0000_0000, 1'b1, 32'h8000_0007});
    tbl.push_back('{1'b0, 1'b1, 8'd0, 32'h8000_0000, 1'b0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 8'd0, 32'h0000_0000, 1'b1, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 8'd5, 32'h0000_0000, 1'b0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b1, 8'd0, 32'h4000_0001, 1'b0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 8'd0, 32'h0000_0000, 1'b1, 32'h4000_0001});
    tbl.push_back('{1'b1, 1'b0, 8'd1, 32'h0000_0000, 1'b1, 32'h2041_4C4F});
    tbl.push_back('{1'b1, 1'b0, 8'd1, 32'h0000_0000, 1'b1, 32'h2045_564F});
    tbl.push_back('{1'b0, 1'b0, 8'd0, 32'h0000_0000, 1'b0, 32'h0000_0000});
    tbl.push_back('{1'b0, 1'b1, 8'd1, 32'h0000_0003, 1'b0, 32'h0000_0000});
    tbl.push_back('{1'b0, 1'b1, 8'd0, 32'h4000_0005, 1'b0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 8'd1, 32'h0000_0000, 1'b1, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 8'd0, 32'h0000_0000, 1'b1, 32'hC000_0000});
    tbl.push_back('{1'b0, 1'b1, 8'd0, 32'h8000_0000, 1'b0, 32'h0000_0000});
    tbl.push_back('{1'b1, 1'b0, 8'd0, 32'h0000_0000, 1'b1, 32'h0000_0000});

    foreach (tbl[i]) begin
      tick(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, mv, md);
      check($sformatf("tbl[%0d]", i),
            {bus1.avs_csr_readdatavalid, bus1.avs_csr_readdata}, {tbl[i].ev, tbl[i].ed});
    end
    idle(3);

    // back-to-back reads: latency-3 instance must show valid exactly two cycles later, twice
    tick(1'b0, 1'b1, 8'd0, 32'h0000_0003, mv, md);
    tick(1'b1, 1'b0, 8'd1, 32'h0, mv, md);
    tick(1'b1, 1'b0, 8'd0, 32'h0, mv, md);
    tick(1'b0, 1'b0, 8'd0, 32'h0, mv, md);
    check("l3_t3", {bus3.avs_csr_readdatavalid, bus3.avs_csr_readdata}, {1'b1, 32'h504D_5558});
    tick(1'b0, 1'b0, 8'd0, 32'h0, mv, md);
    check("l3_t4", {bus3.avs_csr_readdatavalid, bus3.avs_csr_readdata}, {1'b1, 32'h0000_0003});
    idle(3);

    // reset while two reads are still inside the latency-3 pipe
    tick(1'b1, 1'b0, 8'd1, 32'h0, mv, md);
    tick(1'b1, 1'b0, 8'd0, 32'h0, mv, md);
    do_reset(4);
    idle(4);

    for (int i = 0; i < 600; i++) begin
      int          op;
      logic [31:0] wd;
      op = $urandom_range(0, 9);
      wd = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 14'($urandom),
            16'($urandom_range(0, 5))};
      if (i == 300) do_reset(2);
      case (op)
        0, 1, 2, 3: tick(1'b1, 1'b0, 8'd1, 32'h0, mv, md);
        4, 5:       tick(1'b1, 1'b0, 8'd0, 32'h0, mv, md);
        6, 7:       tick(1'b0, 1'b1, 8'd0, wd, mv, md);
        8:          tick(1'b1, 1'b1, 8'($urandom_range(0, 1)), wd, mv, md);
        default:    tick(1'($urandom_range(0, 1)), 1'b0, 8'($urandom_range(2, 7)), wd, mv, md);
      endcase
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
